sram_axi_bridge: RTL and testbench

Converts the CPU core's two SRAM-like master ports (instruction and data) into a single AXI master port for the SoC interconnect. Sits directly downstream of the CPU top and consumes its `inst_sram_*` and `data_sram_*` request streams. Handles one transaction at a time, arbitrating between the two ports. Returns read data and write completions to whichever port originated the request.

---
 rtl/sram_axi_bridge.sv | 176 +++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: folds the CPU's instruction and data SRAM-like ports onto
// one single-beat AXI master, one transaction at a time.
// Optional build macro BRIDGE_DATA_PRIORITY_EN: data port always wins
// arbitration and the round-robin pointer is removed.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    // instruction port
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    // R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AW channel
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    // W channel
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    // B channel
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

    state_t      state, state_nxt;
    logic        sel_inst, sel_data, accept;
    logic        req_src;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] rdata_q;
    logic        aw_done, w_done, aw_fire, w_fire;
    logic [3:0]  unused_rid;

    // Only one read is ever outstanding, so the returned ID carries no information.
    assign unused_rid = rid;

`ifndef BRIDGE_DATA_PRIORITY_EN
    logic        prio_inst;
`endif

    // Pick at most one requester per cycle.
    always_comb begin
`ifdef BRIDGE_DATA_PRIORITY_EN
        sel_data = data_req;
`else
        sel_data = data_req && (!inst_req || !prio_inst);
`endif
        sel_inst = inst_req && !sel_data;
    end

    assign accept  = (state == IDLE) && (sel_inst || sel_data);
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

`ifndef BRIDGE_DATA_PRIORITY_EN
    // Round-robin pointer: the port just served yields priority to the other.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     prio_inst <= 1'b0;
        else if (accept) prio_inst <= sel_data;
    end
`endif

    // Latch the accepted request; AXI address/data outputs come from here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_src  <= 1'b0;
            req_wr   <= 1'b0;
            req_size <= 2'd0;
            req_addr <= 32'd0;
            wdata    <= 32'd0;
            wstrb    <= 4'd0;
        end else if (accept) begin
            req_src  <= sel_data;
            req_wr   <= sel_data ? data_wr    : inst_wr;
            req_size <= sel_data ? data_size  : inst_size;
            req_addr <= sel_data ? data_addr  : inst_addr;
            wdata    <= sel_data ? data_wdata : inst_wdata;
            wstrb    <= sel_data ? data_wstrb : inst_wstrb;
        end
    end

    assign arid   = {3'b000, req_src};
    assign araddr = req_addr;
    assign awaddr = req_addr;
    assign arsize = {1'b0, req_size};
    assign awsize = {1'b0, req_size};

    // Remember which write channel has already handshaken while in WR_REQ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state != WR_REQ) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
        end
    end

    // Hold the last read beat for the response port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                        rdata_q <= 32'd0;
        else if (state == RD_DATA && rvalid) rdata_q <= rdata;
    end

    assign inst_rdata = rdata_q;
    assign data_rdata = rdata_q;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (sel_data ? data_wr : inst_wr) ? WR_REQ : RD_ADDR;
            RD_ADDR: if (arready) state_nxt = RD_DATA;
            RD_DATA: if (rvalid) state_nxt = RESP;
            WR_REQ:  if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = WR_RESP;
            WR_RESP: if (bvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; addr_ok is also masked while reset is held.
    always_comb begin
        inst_addr_ok = resetn && (state == IDLE) && sel_inst;
        data_addr_ok = resetn && (state == IDLE) && sel_data;
        arvalid      = (state == RD_ADDR);
        rready       = (state == RD_DATA);
        awvalid      = (state == WR_REQ) && !aw_done;
        wvalid       = (state == WR_REQ) && !w_done;
        bready       = (state == WR_RESP);
        inst_data_ok = (state == RESP) && !req_src;
        data_data_ok = (state == RESP) &&  req_src;
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a response scoreboard.
// Honours BRIDGE_DATA_PRIORITY_EN when the build defines it.
module tb_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    typedef struct packed {
        logic        src;
        logic        is_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected response and compare it against the RESP cycle outputs.
    task automatic check_resp();
        exp_t e;
        chk_b("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk_b("inst_data_ok", inst_data_ok, !e.src);
            chk_b("data_data_ok", data_data_ok, e.src);
            if (e.is_rd)
                chk_w(e.src ? "data_rdata" : "inst_rdata", e.src ? data_rdata : inst_rdata, e.rd);
        end
    endtask

    // Accept one request from the expected port and run it against a zero-wait slave.
    task automatic serve(input logic exp_data, input logic drop, input logic [31:0] rd_val);
        logic        e_wr;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_addr, e_wdata;
        e_wr    = exp_data ? data_wr    : inst_wr;
        e_size  = exp_data ? data_size  : inst_size;
        e_wstrb = exp_data ? data_wstrb : inst_wstrb;
        e_addr  = exp_data ? data_addr  : inst_addr;
        e_wdata = exp_data ? data_wdata : inst_wdata;
        chk_b("inst_addr_ok", inst_addr_ok, !exp_data);
        chk_b("data_addr_ok", data_addr_ok, exp_data);
        sb.push_back('{src: exp_data, is_rd: !e_wr, rd: rd_val});
        tick();
        if (drop) begin
            if (exp_data) data_req = 1'b0;
            else          inst_req = 1'b0;
        end
        #1;
        chk_b("addr_ok_busy", inst_addr_ok | data_addr_ok, 1'b0);
        if (!e_wr) begin
            chk_b("arvalid", arvalid, 1'b1);
            chk_w("araddr", araddr, e_addr);
            chk_w("arsize", 32'(arsize), 32'({1'b0, e_size}));
            chk_w("arid", 32'(arid), 32'(exp_data));
            chk_b("awvalid_rd", awvalid, 1'b0);
            arready = 1'b1;
            tick();
            arready = 1'b0;
            chk_b("rready", rready, 1'b1);
            chk_b("arvalid_off", arvalid, 1'b0);
            rvalid = 1'b1;
            rdata  = rd_val;
            tick();
            rvalid = 1'b0;
        end else begin
            chk_b("awvalid", awvalid, 1'b1);
            chk_b("wvalid", wvalid, 1'b1);
            chk_w("awaddr", awaddr, e_addr);
            chk_w("awsize", 32'(awsize), 32'({1'b0, e_size}));
            chk_w("wdata", wdata, e_wdata);
            chk_w("wstrb", 32'(wstrb), 32'(e_wstrb));
            chk_b("arvalid_wr", arvalid, 1'b0);
            awready = 1'b1;
            wready  = 1'b1;
            tick();
            awready = 1'b0;
            wready  = 1'b0;
            chk_b("bready", bready, 1'b1);
            chk_b("aw_w_off", awvalid | wvalid, 1'b0);
            bvalid = 1'b1;
            tick();
            bvalid = 1'b0;
        end
        check_resp();
        tick();
        chk_b("data_ok_pulse", inst_data_ok | data_data_ok, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_wstrb = 4'd0;
        inst_addr = 32'd0; inst_wdata = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        // Reset values
        #1;
        chk_b("rst_valids", arvalid | awvalid | wvalid, 1'b0);
        chk_b("rst_readys", rready | bready, 1'b0);
        chk_b("rst_oks", inst_addr_ok | data_addr_ok | inst_data_ok | data_data_ok, 1'b0);
        chk_w("rst_araddr", araddr, 32'd0);
        chk_w("rst_awaddr", awaddr, 32'd0);
        chk_w("rst_wdata", wdata, 32'd0);
        chk_w("rst_wstrb", 32'(wstrb), 32'd0);
        chk_w("rst_arid", 32'(arid), 32'd0);
        chk_w("rst_rdata", inst_rdata | data_rdata, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Single instruction read
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0000;
        #1;
        serve(1'b0, 1'b1, 32'h3C1D_0001);

        // Data write: AW accepted first, W stalled until T3
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_1000;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        #1;
        chk_b("w_addr_ok", data_addr_ok, 1'b1);
        chk_b("w_inst_addr_ok", inst_addr_ok, 1'b0);
        sb.push_back('{src: 1'b1, is_rd: 1'b0, rd: 32'd0});
        tick();                                   // T1
        data_req = 1'b0;
        chk_b("w_t1_awvalid", awvalid, 1'b1);
        chk_b("w_t1_wvalid", wvalid, 1'b1);
        chk_w("w_t1_awaddr", awaddr, 32'h8000_1000);
        chk_w("w_t1_wdata", wdata, 32'hDEAD_BEEF);
        chk_w("w_t1_wstrb", 32'(wstrb), 32'hF);
        awready = 1'b1;
        tick();                                   // T2
        awready = 1'b0;
        chk_b("w_t2_awvalid", awvalid, 1'b0);
        chk_b("w_t2_wvalid", wvalid, 1'b1);
        chk_b("w_t2_bready", bready, 1'b0);
        tick();                                   // T3
        chk_b("w_t3_wvalid", wvalid, 1'b1);
        chk_w("w_t3_wdata", wdata, 32'hDEAD_BEEF);
        chk_b("w_t3_data_ok", data_data_ok, 1'b0);
        wready = 1'b1;
        tick();                                   // T4
        wready = 1'b0;
        chk_b("w_t4_wvalid", wvalid, 1'b0);
        chk_b("w_t4_bready", bready, 1'b1);
        chk_b("w_t4_data_ok", data_data_ok, 1'b0);
        bvalid = 1'b1;
        tick();                                   // T5
        bvalid = 1'b0;
        check_resp();
        tick();                                   // T6
        chk_b("w_t6_data_ok", data_data_ok, 1'b0);

        // Simultaneous requests, starting from a fresh reset
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_2000;
        inst_req = 1'b1; inst_wr = 1'b1; inst_size = 2'd1; inst_addr = 32'h1FC0_0100;
        inst_wstrb = 4'h3; inst_wdata = 32'h1234_5678;
        #1;
`ifdef BRIDGE_DATA_PRIORITY_EN
        serve(1'b1, 1'b0, 32'hA000_0001);
        serve(1'b1, 1'b0, 32'hA000_0002);
        serve(1'b1, 1'b0, 32'hA000_0003);
`else
        serve(1'b1, 1'b0, 32'hA000_0001);
        serve(1'b0, 1'b0, 32'hA000_0002);
        serve(1'b1, 1'b0, 32'hA000_0003);
`endif
        data_req = 1'b0;
        #1;
        serve(1'b0, 1'b1, 32'hA000_0004);

        // Read with AR backpressure for 4 cycles
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_3004;
        #1;
        chk_b("bp_addr_ok", data_addr_ok, 1'b1);
        sb.push_back('{src: 1'b1, is_rd: 1'b1, rd: 32'h5555_AAAA});
        tick();                                   // T1
        data_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_b("bp_arvalid", arvalid, 1'b1);
            chk_w("bp_araddr", araddr, 32'h8000_3004);
            chk_b("bp_data_ok", data_data_ok, 1'b0);
            tick();
        end
        chk_b("bp_t5_arvalid", arvalid, 1'b1);    // T5
        arready = 1'b1;
        tick();                                   // T6
        arready = 1'b0;
        chk_b("bp_t6_rready", rready, 1'b1);
        rvalid = 1'b1;
        rdata  = 32'h5555_AAAA;
        tick();                                   // T7
        rvalid = 1'b0;
        check_resp();
        tick();
        chk_b("bp_t8_data_ok", data_data_ok, 1'b0);

        // Reset asserted while waiting for R
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1FC0_0040;
        #1;
        chk_b("mr_addr_ok", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;
        arready  = 1'b1;
        tick();
        arready  = 1'b0;
        chk_b("mr_rready_pre", rready, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk_b("mr_rready", rready, 1'b0);
        chk_b("mr_valids", arvalid | awvalid | wvalid | bready, 1'b0);
        chk_b("mr_data_ok", inst_data_ok | data_data_ok, 1'b0);
        chk_w("mr_rdata", inst_rdata, 32'd0);
        data_req = 1'b1;
        #1;
        chk_b("mr_addr_ok_rst", data_addr_ok | inst_addr_ok, 1'b0);
        data_req = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h1FC0_0080;
        #1;
        serve(1'b0, 1'b1, 32'h0BAD_F00D);
        chk_b("sb_drained", sb.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
